run_len_det: RTL and testbench
==============================

# run_len_det

Parametrised run-length detector for a serial bit stream: flags when RUN_LEN consecutive equal bits have been accepted. The mode selects ones, zeros or either, and overlapping or non-overlapping counting. It also keeps a saturating count of detections. It sits on the same serial-input paths as the fixed pair detector and replaces it wherever run length, polarity or flow control must be configurable; RUN_LEN=2 with MODE_EITHER and overlap=1 reproduces pair (00/11) detection.

## Interface
- RUN_LEN, 2: run length to detect; legal range 2..255.
- CNT_W, 8: width of detection counter det_count.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_bit is consumed on this clock edge when high.
- in_bit  in  1  serial data bit.
- mode  in  2  polarity select: 00 either, 01 ones only, 10 zeros only, 11 disabled (never detects).
- overlap  in  1  1 = run keeps detecting on every further equal bit; 0 = run restarts after each detection.
- count_clr  in  1  synchronous clear of det_count.
- out  out  1  registered detection flag (Moore: function of stored state and mode).
- out_bit  out  1  value of the current run's bit (last accepted bit).
- det_count  out  CNT_W  saturating number of detections since reset/clear.

## Operation
- State: have_prev (0 after reset = IDLE), last_bit, run_cnt (8 bits, range 0..RUN_LEN).
- Accepted bit (in_valid=1):
  - !have_prev: run_cnt←1, last_bit←in_bit, have_prev←1.
  - in_bit≠last_bit: run_cnt←1, last_bit←in_bit.
  - in_bit==last_bit and run_cnt<RUN_LEN: run_cnt←run_cnt+1.
  - in_bit==last_bit and run_cnt==RUN_LEN: overlap=1 → stays RUN_LEN; overlap=0 → run_cnt←1.
- in_valid=0: state unchanged, out holds except for mode-change effect below.
- match(b, mode): mode 00 → 1; 01 → b; 10 → !b; 11 → 0.
- out register ← (run_cnt_next==RUN_LEN) && match(last_bit_next, mode), evaluated every cycle. A mode change takes effect on out the next cycle even with no valid bit.
- Detection event: an accepted bit for which run_cnt_next==RUN_LEN and match(in_bit, mode).
- det_count: increments by 1 per detection event and saturates at 2^CNT_W−1, with no wrap. count_clr has priority over increment; the same-cycle result is 0, and that detection is lost.
- overlap and mode changes do not alter run_cnt; they apply from the next accepted bit.

## Timing
- Reset values: out=0, out_bit=0, det_count=0, have_prev=0, run_cnt=0.
- Latency: the bit completing a run, accepted at edge k, drives out=1 after edge k. That is one cycle from presenting the bit, as in the pair detector.
- Overlap=1: out stays high across consecutive equal accepted bits and across in_valid gaps. Overlap=0: out is high for exactly the state following the completing bit, until the next accepted bit.
- Reset mid-run: all state clears at that edge. The first bit after reset starts a new run of 1 and history is discarded.
- reset has priority over in_valid and count_clr.
- No combinational path from any input to any output.

## Structure
- Package run_len_det_pkg: mode constants MODE_EITHER=2'b00, MODE_ONES=2'b01, MODE_ZEROS=2'b10, MODE_OFF=2'b11, and the match function.
- One sub-module, run_len_det_sat_cnt (CNT_W parameter; inc, clr; saturating), used for det_count.
- Static elaboration check: RUN_LEN outside 2..255 is a fatal error.

## Test plan
- RUN_LEN=3, mode 00, overlap=1, bits 0,0,1,1,1,1,0, all valid → out=1 only after the 5th and 6th bits, out_bit=1 then; det_count=2.
- RUN_LEN=3, overlap=0, six 1s → out=1 after bits 3 and 6 only; det_count=2.
- RUN_LEN=3, mode 01, bits 0,0,0,0 → out stays 0, det_count=0. Then switch to mode 10 with no valid bit → out=1 the next cycle; det_count stays 0.
- RUN_LEN=2, overlap=1, bits 1,_,1 (in_valid=0 for 3 cycles in the gap) → out=1 after the second 1; it holds while in_valid=0.
- CNT_W=2, 5 detections → det_count=3, saturated. count_clr asserted on the same edge as a detection → det_count=0.
- Reset asserted after bits 1,1 (RUN_LEN=3), then bit 1 → out=0 and run_cnt=1; two more 1s → out=1.

Source files
------------

// File: rtl/run_len_det_pkg.sv
// Shared mode encodings, run-tracking state and the polarity match helper
// for the run-length detector.
package run_len_det_pkg;

  localparam logic [1:0] MODE_EITHER = 2'b00;
  localparam logic [1:0] MODE_ONES   = 2'b01;
  localparam logic [1:0] MODE_ZEROS  = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  typedef struct packed {
    logic       have_prev;
    logic       last_bit;
    logic [7:0] run_cnt;
  } run_state_t;

  function automatic logic match(input logic b, input logic [1:0] mode);
    case (mode)
      MODE_EITHER: match = 1'b1;
      MODE_ONES:   match = b;
      MODE_ZEROS:  match = ~b;
      default:     match = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/run_len_det_sat_cnt.sv
// Saturating up-counter; clear wins over increment.
module run_len_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr)              cnt <= '0;
    else if (inc && (cnt != '1))   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/run_len_det.sv
// Run-length detector: flags RUN_LEN consecutive equal accepted bits,
// polarity/overlap configurable, with a saturating detection counter.
module run_len_det
  import run_len_det_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             count_clr,
  output logic             out,
  output logic             out_bit,
  output logic [CNT_W-1:0] det_count
);

  generate
    if (RUN_LEN < 2 || RUN_LEN > 255) begin : g_bad_run_len
      $fatal(1, "run_len_det: RUN_LEN=%0d outside 2..255", RUN_LEN);
    end
  endgenerate

  localparam logic [7:0] RUN_MAX = 8'(RUN_LEN);

  run_state_t st, st_nxt;
  logic       out_nxt;
  logic       det_ev;

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= '0;
      out <= 1'b0;
    end else begin
      st  <= st_nxt;
      out <= out_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    if (in_valid) begin
      if (!st.have_prev) begin
        st_nxt.have_prev = 1'b1;
        st_nxt.last_bit  = in_bit;
        st_nxt.run_cnt   = 8'd1;
      end else if (in_bit != st.last_bit) begin
        st_nxt.last_bit  = in_bit;
        st_nxt.run_cnt   = 8'd1;
      end else if (st.run_cnt < RUN_MAX) begin
        st_nxt.run_cnt   = st.run_cnt + 8'd1;
      end else if (!overlap) begin
        // Non-overlapping: the bit after a full run opens a fresh run.
        st_nxt.run_cnt   = 8'd1;
      end
    end
  end

  // out re-evaluates every cycle so a mode change shows up without a new bit.
  always_comb begin
    out_nxt = (st_nxt.run_cnt == RUN_MAX) && match(st_nxt.last_bit, mode);
    det_ev  = in_valid && (st_nxt.run_cnt == RUN_MAX) && match(in_bit, mode);
  end

  assign out_bit = st.last_bit;

  run_len_det_sat_cnt #(.CNT_W(CNT_W)) u_det_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (det_ev),
    .clr   (count_clr),
    .cnt   (det_count)
  );

endmodule

// File: tb/tb_run_len_det.sv
// Directed bench for run_len_det: RUN_LEN=3/CNT_W=8 and RUN_LEN=2/CNT_W=2
// instances share one stimulus bus; each scenario checks the relevant one.
module tb_run_len_det;
  import run_len_det_pkg::*;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_bit, overlap, count_clr;
  logic [1:0] mode;
  logic       out3, out_bit3, out2, out_bit2;
  logic [7:0] det3;
  logic [1:0] det2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  run_len_det #(.RUN_LEN(3), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .mode(mode), .overlap(overlap), .count_clr(count_clr),
    .out(out3), .out_bit(out_bit3), .det_count(det3)
  );

  run_len_det #(.RUN_LEN(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .mode(mode), .overlap(overlap), .count_clr(count_clr),
    .out(out2), .out_bit(out_bit2), .det_count(det2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock with the given inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    count_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  logic [6:0] t1_bits = 7'b0011110;  // MSB first: 0,0,1,1,1,1,0
  logic [6:0] t1_out  = 7'b0000110;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    overlap = 1'b1; count_clr = 1'b0; mode = MODE_EITHER;
    #2;

    // Reset state
    do_reset();
    chk("rst_out", out3, 0);
    chk("rst_out_bit", out_bit3, 0);
    chk("rst_det", det3, 0);

    // Overlapping, either polarity
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, t1_bits[i]);
      chk($sformatf("ovl_out_b%0d", 7 - i), out3, t1_out[i]);
      if (i == 2) chk("ovl_out_bit", out_bit3, 1);
    end
    chk("ovl_det", det3, 2);

    // Non-overlapping, six ones
    do_reset();
    overlap = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("novl_out_b%0d", i), out3, (i == 3 || i == 6) ? 1 : 0);
    end
    chk("novl_det", det3, 2);

    // Ones-only sees zeros: nothing; then switch to zeros-only with no bit
    do_reset();
    overlap = 1'b1;
    mode = MODE_ONES;
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("ones_out_b%0d", i), out3, 0);
    end
    chk("ones_det", det3, 0);
    mode = MODE_ZEROS;
    step(1'b0, 1'b0);
    chk("mode_sw_out", out3, 1);
    chk("mode_sw_det", det3, 0);
    mode = MODE_OFF;
    step(1'b0, 1'b0);
    chk("mode_off_out", out3, 0);

    // RUN_LEN=2 with an in_valid gap
    do_reset();
    mode = MODE_EITHER;
    step(1'b1, 1'b1);
    chk("gap_out_first", out2, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("gap_out_mid", out2, 0);
    step(1'b1, 1'b1);
    chk("gap_out_pair", out2, 1);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0);
      chk($sformatf("gap_hold_%0d", i), out2, 1);
    end

    // Saturation of 2-bit counter, then clear racing a detection
    do_reset();
    step(1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("sat_det_%0d", i), det2, (i < 3) ? i : 3);
    end
    count_clr = 1'b1;
    step(1'b1, 1'b1);
    chk("clr_vs_det", det2, 0);
    step(1'b1, 1'b1);
    chk("det_after_clr", det2, 1);

    // Reset mid-run discards history; reset beats in_valid
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    reset = 1'b1;
    step(1'b1, 1'b1);
    reset = 1'b0;
    chk("midrst_out", out3, 0);
    chk("midrst_out_bit", out_bit3, 0);
    step(1'b1, 1'b1);
    chk("post_rst_b1_out", out3, 0);
    chk("post_rst_b1_bit", out_bit3, 1);
    step(1'b1, 1'b1);
    chk("post_rst_b2_out", out3, 0);
    step(1'b1, 1'b1);
    chk("post_rst_b3_out", out3, 1);
    chk("post_rst_det", det3, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
